comparator_seq: RTL and testbench

- Parametrised, multi-cycle magnitude comparator; successor to the 32-bit combinational comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
- Supports signed or unsigned compare, selected per transaction.
- Uses valid/ready handshakes on input and output, so it sits directly in datapath pipelines (ALU compare, branch resolve) where a WIDTH-wide single-cycle compare would miss timing.

---
 rtl/comparator_seq.sv | 133 +++++++++++++
 tb/tb_comparator_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, signed or unsigned per transaction.
// Latency: result valid NCHUNK cycles after acceptance (earlier on the first differing chunk when COMPARATOR_SEQ_EARLY_EXIT_EN is defined; EQ always takes NCHUNK).
// Backpressure: ready_o low from acceptance until the result handshake completes; result and valid_o held while ready_i is low.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), asynchronous active-low reset
//   valid_i/ready_o         operand handshake; a_i, b_i, signed_i sampled on acceptance
//   valid_o/ready_i         result handshake; gt_o/lt_o/eq_o one-hot while valid_o=1
// Optional build macro: COMPARATOR_SEQ_EARLY_EXIT_EN (leave BUSY on the first unequal chunk).
module comparator_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             gt_o,
    output logic             lt_o,
    output logic             eq_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDXW-1:0]  idx;
    logic             decided;   // an unequal chunk has already been seen
    logic             dec_gt;    // direction of that first unequal chunk

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic             cur_ne;
    logic             cur_gt;
    logic             fin_dec;
    logic             fin_gt;
    logic             leave_busy;

    // Current chunk selected by shifting so the index arithmetic stays width-clean.
    assign a_sh = a_r >> (CHUNK * int'(idx));
    assign b_sh = b_r >> (CHUNK * int'(idx));
    assign a_ch = a_sh[CHUNK-1:0];
    assign b_ch = b_sh[CHUNK-1:0];
    assign cur_ne = (a_ch != b_ch);
    assign cur_gt = (a_ch > b_ch);

    // Higher chunks dominate: an earlier decision always wins over the current step.
    assign fin_dec = decided | cur_ne;
    assign fin_gt  = decided ? dec_gt : cur_gt;

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    assign leave_busy = (idx == '0) || cur_ne;
`else
    assign leave_busy = (idx == '0);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            gt_o    <= 1'b0;
            lt_o    <= 1'b0;
            eq_o    <= 1'b0;
            idx     <= IDX_TOP;
            a_r     <= '0;
            b_r     <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        // Flipping the sign bit maps two's complement onto offset
                        // binary, so the unsigned chunk compare orders signed values.
                        a_r     <= signed_i ? (a_i ^ MSB_MASK) : a_i;
                        b_r     <= signed_i ? (b_i ^ MSB_MASK) : b_i;
                        idx     <= IDX_TOP;
                        decided <= 1'b0;
                        dec_gt  <= 1'b0;
                        ready_o <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!decided && cur_ne) begin
                        decided <= 1'b1;
                        dec_gt  <= cur_gt;
                    end
                    if (leave_busy) begin
                        gt_o    <= fin_dec & fin_gt;
                        lt_o    <= fin_dec & ~fin_gt;
                        eq_o    <= ~fin_dec;
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idx <= idx - IDXW'(1);
                    end
                end
                DONE: begin
                    if (valid_o && ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_seq.sv
// Self-checking bench for comparator_seq (WIDTH=32, CHUNK=8): directed cases plus randomized transactions against a reference model.
// Latency: bench measures cycles from acceptance edge to valid_o and compares with the model.
// Backpressure: exercises held results under ready_i=0, ignored operand pulses, and asynchronous reset mid-operation.
module tb_comparator_seq;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             signed_i;
    logic             valid_o;
    logic             ready_i;
    logic             gt_o;
    logic             lt_o;
    logic             eq_o;

    int n_vec = 0;
    int n_err = 0;

    comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .signed_i (signed_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .gt_o     (gt_o),
        .lt_o     (lt_o),
        .eq_o     (eq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference result {gt, lt, eq} from plain integer comparison.
    function automatic logic [2:0] model_res(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) begin
            if ($signed(a) > $signed(b)) return 3'b100;
            if ($signed(a) < $signed(b)) return 3'b010;
            return 3'b001;
        end
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        return 3'b001;
    endfunction

    // Reference latency: the highest differing bit decides which chunk ends the compare.
    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
        logic [31:0] x;
        x = a ^ b;
        for (int p = WIDTH - 1; p >= 0; p--) begin
            if (x[p]) return NCHUNK - (p / CHUNK);
        end
        return NCHUNK;
`else
        return NCHUNK + 0 * int'(a[0] ^ b[0]);
`endif
    endfunction

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!ready_o && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        ok = ready_o;
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int hold, input bit pulse);
        logic [2:0] er;
        int         el;
        int         lat;
        bit         ok;
        er = model_res(a, b, s);
        el = model_lat(a, b);
        wait_ready(ok);
        if (!ok) return;
        a_i = a; b_i = b; signed_i = s; valid_i = 1'b1; ready_i = 1'b0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        // Scramble the inputs after acceptance; the result must not follow them.
        a_i = $urandom; b_i = $urandom; signed_i = 1'($urandom);
        check("busy_ready", {31'd0, ready_o}, 32'd0);
        lat = 0;
        while (!valid_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!valid_o) begin
            check("result_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", lat, el);
        check("result", {29'd0, gt_o, lt_o, eq_o}, {29'd0, er});
        check("onehot", 32'(gt_o) + 32'(lt_o) + 32'(eq_o), 32'd1);
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 1) begin
                a_i = ~a; b_i = a; signed_i = ~s; valid_i = 1'b1;
            end
            @(posedge clk_i); #1;
            valid_i = 1'b0;
            check("hold_valid", {31'd0, valid_o}, 32'd1);
            check("hold_ready", {31'd0, ready_o}, 32'd0);
            check("hold_result", {29'd0, gt_o, lt_o, eq_o}, {29'd0, er});
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check("drop_valid", {31'd0, valid_o}, 32'd0);
        check("idle_ready", {31'd0, ready_o}, 32'd1);
        check("retain_result", {29'd0, gt_o, lt_o, eq_o}, {29'd0, er});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          ok;
        rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        a_i = '0; b_i = '0; signed_i = 1'b0;
        #12;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_result", {29'd0, gt_o, lt_o, eq_o}, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_ready", {31'd0, ready_o}, 32'd1);

        // Directed cases.
        run_txn(32'h0000_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0, 1'b0);
        run_txn(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        run_txn(32'h7777_7777, 32'h5555_5555, 1'b0, 0, 1'b0);
        run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, 1'b0);
        run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        run_txn(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 1'b0);
        run_txn(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0);
        run_txn(32'h1234_0000, 32'h1233_FFFF, 1'b0, 0, 1'b0);

        // Backpressure with an ignored operand pulse, then a follow-up transaction.
        run_txn(32'h0000_1000, 32'h0000_2000, 1'b0, 3, 1'b1);
        run_txn(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);

        // Asynchronous reset two steps into BUSY.
        wait_ready(ok);
        if (ok) begin
            a_i = 32'hAAAA_0000; b_i = 32'hAAAA_0001; signed_i = 1'b0; valid_i = 1'b1;
            @(posedge clk_i); #1;
            valid_i = 1'b0;
            @(posedge clk_i);
            @(posedge clk_i);
            #2;
            rst_n_i = 1'b0;
            #1;
            check("abort_valid", {31'd0, valid_o}, 32'd0);
            check("abort_ready", {31'd0, ready_o}, 32'd1);
            check("abort_result", {29'd0, gt_o, lt_o, eq_o}, 32'd0);
            @(negedge clk_i);
            rst_n_i = 1'b1;
            // The aborted transaction must not surface after release.
            for (int i = 0; i < NCHUNK + 1; i++) begin
                @(posedge clk_i); #1;
                check("abort_no_result", {31'd0, valid_o}, 32'd0);
            end
        end
        run_txn(32'd5, 32'd9, 1'b0, 0, 1'b0);

        // Randomized transactions, biased toward shared high chunks and equality.
        for (int t = 0; t < 60; t++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = ra;
                2: rb = ra ^ (32'd1 << $urandom_range(0, 31));
                default: rb = {ra[31:16], 16'($urandom)};
            endcase
            run_txn(ra, rb, 1'($urandom), $urandom_range(0, 2), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
